// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // MUL only keeps the low word, so treating it as signed is harmless.
    function automatic logic rs1_is_signed(op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_is_signed(op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide
// on one shared magnitude datapath, with sign fixup at the final iteration.
//   state | meaning
//   IDLE  | waiting for start_i; accept latches operands
//   CALC  | one multiply/divide iteration per edge
//   DONE  | result_o valid for one cycle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    state_e                  state;
    op_e                     op_q;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic                    sign_a, sign_b;
    logic [DATA_WIDTH-1:0]   result_q;

    op_e                     op_in;
    logic                    s1, s2, is_div_in, special;
    logic [DATA_WIDTH-1:0]   mag1, mag2, special_val;

    always_comb begin
        op_in       = op_e'(op_i);
        s1          = rs1_is_signed(op_in) && rs1_data_i[DATA_WIDTH-1];
        s2          = rs2_is_signed(op_in) && rs2_data_i[DATA_WIDTH-1];
        mag1        = s1 ? -rs1_data_i : rs1_data_i;
        mag2        = s2 ? -rs2_data_i : rs2_data_i;
        is_div_in   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        special     = 1'b0;
        special_val = '0;
        if (is_div_in && rs2_data_i == '0) begin
            special     = 1'b1;
            special_val = (op_in inside {OP_REM, OP_REMU}) ? rs1_data_i : ALL_ONES;
        end else if ((op_in inside {OP_DIV, OP_REM}) &&
                     rs1_data_i == INT_MIN && rs2_data_i == ALL_ONES) begin
            special     = 1'b1;
            special_val = (op_in == OP_REM) ? '0 : INT_MIN;
        end
    end

    logic                    is_div_q, ge;
    logic [DATA_WIDTH:0]     mul_sum, shifted;
    logic [DATA_WIDTH-1:0]   next_hi, next_lo;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;
    logic [DATA_WIDTH-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted  = {acc_hi, acc_lo[DATA_WIDTH-1]};
        ge       = shifted >= {1'b0, opnd};
        if (is_div_q) begin
            next_hi = ge ? (shifted[DATA_WIDTH-1:0] - opnd) : shifted[DATA_WIDTH-1:0];
            next_lo = {acc_lo[DATA_WIDTH-2:0], ge};
        end else begin
            next_hi = mul_sum[DATA_WIDTH:1];
            next_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
        end
        // Magnitudes were latched, so the sign is restored on the final value.
        prod     = {next_hi, next_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix = (sign_a ^ sign_b) ? -next_lo : next_lo;
        rem_fix  = sign_a ? -next_hi : next_hi;
        case (op_q)
            OP_MUL:                         final_res = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   final_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:                final_res = quot_fix;
            default:                        final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        op_q   <= op_in;
                        sign_a <= s1;
                        sign_b <= s2;
                        cnt    <= '0;
                        acc_hi <= '0;
                        opnd   <= is_div_in ? mag2 : mag1;
                        acc_lo <= is_div_in ? mag1 : mag2;
                        if (special) begin
                            result_q <= special_val;
                            state    <= ST_DONE;
                        end else begin
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else begin
                        acc_hi <= next_hi;
                        acc_lo <= next_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            result_q <= final_res;
                            state    <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so a held start_i cannot keep the stall up during reset.
    assign stall_o  = !rst && ((state == ST_IDLE && start_i) || state == ST_CALC);
    assign busy_o   = state != ST_IDLE;
    assign done_o   = state == ST_DONE;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus per-cycle output compare.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Reference timing: 32 edges of work after accept, or none for special cases.
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_res, m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_left <= 0; m_res <= '0; m_pend <= '0;
        end else if (m_done) begin
            m_done <= 0; m_busy <= 0;
        end else if (m_busy) begin
            if (abort_i) m_busy <= 0;
            else if (m_left == 1) begin m_done <= 1; m_res <= m_pend; end
            else m_left <= m_left - 1;
        end else if (start_i && !abort_i) begin
            m_busy <= 1;
            if (is_special(op_i, rs1_data_i, rs2_data_i)) begin
                m_done <= 1;
                m_res  <= ref_res(op_i, rs1_data_i, rs2_data_i);
            end else begin
                m_left <= 32;
                m_pend <= ref_res(op_i, rs1_data_i, rs2_data_i);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp done_o", {31'b0, done_o}, {31'b0, m_done});
            check("cmp busy_o", {31'b0, busy_o}, {31'b0, m_busy});
            check("cmp stall_o", {31'b0, stall_o},
                  {31'b0, !rst && ((!m_busy && start_i) || (m_busy && !m_done))});
            check("cmp result_o", result_o, m_res);
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_n);
        int n;
        int sc;
        @(posedge clk); #1;
        start_i = 1; op_i = op; rs1_data_i = a; rs2_data_i = b;
        n = 0; sc = 0;
        @(negedge clk); if (stall_o) sc++;
        @(posedge clk);
        do begin
            @(negedge clk); n++;
            if (stall_o) sc++;
        end while (!done_o && n < 100);
        check({name, " result"}, result_o, exp);
        check({name, " done cycle"}, n, exp_n);
        check({name, " stall cycles"}, sc, exp_n);
        @(posedge clk); #1;
        start_i = 0;
        @(negedge clk);
        check({name, " no reaccept"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1; start_i = 0; abort_i = 0; op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        repeat (2) @(posedge clk); #1;
        check("reset done_o", {31'b0, done_o}, 32'd0);
        check("reset busy_o", {31'b0, busy_o}, 32'd0);
        check("reset stall_o", {31'b0, stall_o}, 32'd0);
        check("reset result_o", result_o, 32'd0);
        rst = 0;
        chk_en = 1;

        run_op("MUL 7*-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULH min*min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("REM -7%2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("DIVU big/2",    3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33);
        run_op("DIV 5/0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",      3'd7, 32'd5,          32'd0,         32'd5,         1);
        run_op("DIV ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_op("DIVU 100/7 pre",3'd5, 32'd100,        32'd7,         32'd14,        33);

        // Abort during iteration 10
        @(posedge clk); #1;
        start_i = 1; op_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 abort_i = 1;
        @(posedge clk); #1;
        abort_i = 0; start_i = 0;
        @(negedge clk);
        check("abort busy_o", {31'b0, busy_o}, 32'd0);
        check("abort stall_o", {31'b0, stall_o}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check("abort no done", {31'b0, seen}, 32'd0);
        check("abort keeps result", result_o, 32'd14);
        run_op("DIVU 100/7",    3'd5, 32'd100,        32'd7,         32'd14,        33);

        // Asynchronous reset in the middle of CALC, start_i still high
        @(posedge clk); #1;
        start_i = 1; op_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd5;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        check("async rst done_o", {31'b0, done_o}, 32'd0);
        check("async rst busy_o", {31'b0, busy_o}, 32'd0);
        check("async rst stall_o", {31'b0, stall_o}, 32'd0);
        check("async rst result_o", result_o, 32'd0);
        @(posedge clk); #1 start_i = 0;
        @(posedge clk); #1 rst = 0;

        run_op("MUL after rst", 3'd0, 32'd3,          32'd5,         32'd15,        33);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
